// File: rtl/tff_chain_if.sv
// rtl/tff_chain_if.sv - control and status bundle for the toggle flip-flop chain
//
// Purpose: groups the per-edge controls and the chain outputs so a driver
// and the chain can be connected through one port.
// Signals:
//   data       driver -> chain  toggle enable for stage 0 (gates all stages in counter mode)
//   clr        driver -> chain  synchronous clear
//   load       driver -> chain  synchronous parallel load
//   load_val   driver -> chain  value written to q on load
//   q          chain -> driver  stage outputs, q[0] is the first stage
//   tc         chain -> driver  registered terminal-carry pulse
//   toggle_cnt chain -> driver  saturating count of terminal carries
interface tff_chain_if #(
  parameter int STAGES = 4,
  parameter int CNT_W  = 8
);
  logic              data;
  logic              clr;
  logic              load;
  logic [STAGES-1:0] load_val;
  logic [STAGES-1:0] q;
  logic              tc;
  logic [CNT_W-1:0]  toggle_cnt;

  modport master (
    output data, clr, load, load_val,
    input  q, tc, toggle_cnt
  );

  modport slave (
    input  data, clr, load, load_val,
    output q, tc, toggle_cnt
  );
endinterface

// File: rtl/tff_chain.sv
// rtl/tff_chain.sv - parametrised toggle flip-flop chain with terminal carry
//
// Purpose: STAGES toggle flops, either cascaded (MODE 0, each stage toggles
// on the registered output of the previous one) or as a synchronous binary
// counter (MODE 1). Clear and load are synchronous; reset is asynchronous
// and active-high. tc pulses for one cycle after the last stage falls 1->0.
// Optional feature: define TFF_CHAIN_STATS_EN to build a saturating
// counter of terminal carries on toggle_cnt; otherwise toggle_cnt is 0.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  tff_chain_if.slave: data/clr/load/load_val in, q/tc/toggle_cnt out
module tff_chain #(
  parameter int STAGES = 4,
  parameter int MODE   = 0,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  tff_chain_if.slave  bus
);

  logic [STAGES-1:0] q_q, q_d;
  logic [STAGES-1:0] tog;
  logic              tc_q, tc_d;
  logic              wrap;
  logic              carry;

  // Toggle enables are derived only from registered q, so every stage
  // samples pre-edge values and nothing ripples combinationally.
  always_comb begin
    tog   = '0;
    carry = bus.data;
    if (MODE == 0) begin
      tog[0] = bus.data;
      for (int k = 1; k < STAGES; k++) begin
        tog[k] = q_q[k-1];
      end
    end else begin
      // Stage k toggles when data and all lower stages are ones.
      for (int k = 0; k < STAGES; k++) begin
        tog[k] = carry;
        carry  = carry & q_q[k];
      end
    end
  end

  // Last stage currently 1 and about to toggle: a 1->0 transition.
  assign wrap = tog[STAGES-1] & q_q[STAGES-1];

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (bus.clr) begin
      q_d = '0;
    end else if (bus.load) begin
      q_d = bus.load_val;
    end else begin
      q_d  = q_q ^ tog;
      tc_d = wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign bus.q  = q_q;
  assign bus.tc = tc_q;

`ifdef TFF_CHAIN_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts on the same edge that raises tc; load leaves it untouched.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (tc_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.toggle_cnt = cnt_q;
`else
  assign bus.toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_tff_chain.sv
// tb/tb_tff_chain.sv - scoreboard bench for tff_chain in cascade and counter modes
module tb_tff_chain;

`ifdef TFF_CHAIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tff_chain_if #(.STAGES(3), .CNT_W(8)) b0 ();
  tff_chain_if #(.STAGES(4), .CNT_W(8)) b1 ();
  tff_chain_if #(.STAGES(2), .CNT_W(2)) b2 ();

  tff_chain #(.STAGES(3), .MODE(0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
  tff_chain #(.STAGES(4), .MODE(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
  tff_chain #(.STAGES(2), .MODE(1), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    int          id;
    int          seq;
    logic [15:0] q;
    logic        tc;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   seq    = 0;
  event mon_ev;

  // MODE 0, STAGES 3: data, clr, q, tc, cnt (cnt as seen with stats enabled)
  int t0[15][5] = '{
    '{1,0,1,0,0}, '{1,0,2,0,0}, '{1,0,7,0,0}, '{1,0,0,1,1},
    '{1,0,1,0,1}, '{1,0,2,0,1}, '{1,0,7,0,1}, '{1,0,0,1,2},
    '{1,0,1,0,2}, '{0,0,3,0,2}, '{0,0,5,0,2}, '{0,0,7,0,2},
    '{0,0,1,1,3}, '{0,1,0,0,0}, '{0,0,0,0,0}
  };

  // MODE 1, STAGES 4: data, clr, load, load_val, q, tc, cnt
  int t1[10][7] = '{
    '{0,0,0,0, 1,0,1},  '{0,0,0,0, 1,0,1},
    '{1,0,1,14, 14,0,1}, '{1,0,0,0, 15,0,1},
    '{1,0,1,3, 3,0,1},  '{0,0,1,14, 14,0,1},
    '{1,0,0,0, 15,0,1}, '{1,0,0,0, 0,1,2},
    '{1,0,0,0, 1,0,2},  '{1,1,1,14, 0,0,0}
  };

  task automatic push(input int id, input int q, input bit tc, input int cnt);
    exp_t e;
    e.id  = id;
    e.seq = seq;
    e.q   = 16'(q);
    e.tc  = tc;
    e.cnt = 8'(cnt);
    seq++;
    sb.push_back(e);
  endtask

  task automatic drv0(input bit d, input bit c);
    b0.data = d; b0.clr = c; b0.load = 1'b0; b0.load_val = '0;
  endtask

  task automatic drv1(input bit d, input bit c, input bit l, input int lv);
    b1.data = d; b1.clr = c; b1.load = l; b1.load_val = 4'(lv);
  endtask

  task automatic drv2(input bit d, input bit c);
    b2.data = d; b2.clr = c; b2.load = 1'b0; b2.load_val = '0;
  endtask

  task automatic check(input exp_t e);
    logic [15:0] aq;
    logic        atc;
    logic [7:0]  acnt;
    logic [7:0]  ecnt;
    case (e.id)
      0:       begin aq = 16'(b0.q); atc = b0.tc; acnt = 8'(b0.toggle_cnt); end
      1:       begin aq = 16'(b1.q); atc = b1.tc; acnt = 8'(b1.toggle_cnt); end
      default: begin aq = 16'(b2.q); atc = b2.tc; acnt = 8'(b2.toggle_cnt); end
    endcase
    ecnt = STATS ? e.cnt : 8'd0;
    checks++;
    if (aq !== e.q) begin
      errors++;
      $display("FAIL dut%0d #%0d q: got %0h expected %0h", e.id, e.seq, aq, e.q);
    end
    checks++;
    if (atc !== e.tc) begin
      errors++;
      $display("FAIL dut%0d #%0d tc: got %0b expected %0b", e.id, e.seq, atc, e.tc);
    end
    checks++;
    if (acnt !== ecnt) begin
      errors++;
      $display("FAIL dut%0d #%0d toggle_cnt: got %0d expected %0d", e.id, e.seq, acnt, ecnt);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare shortly after each
  // rising edge, or on demand for checks between edges.
  initial begin
    forever begin
      @(posedge clk or mon_ev);
      #2;
      while (sb.size() > 0) begin
        check(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    drv0(0, 0);
    drv1(0, 0, 0, 0);
    drv2(0, 0);

    // Reset state of all three instances while rst is held.
    @(negedge clk);
    push(0, 0, 0, 0); push(1, 0, 0, 0); push(2, 0, 0, 0);
    ->mon_ev;
    @(negedge clk);
    rst = 1'b0;

    // Cascade mode: full pattern, ripple after data falls, clear.
    for (int s = 0; s < 15; s++) begin
      @(negedge clk);
      drv0(t0[s][0] != 0, t0[s][1] != 0);
      push(0, t0[s][2], t0[s][3] != 0, t0[s][4]);
    end

    // Counter mode: 17 increments through the wrap.
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      drv1(1, 0, 0, 0);
      push(1, i % 16, i == 16, (i >= 16) ? 1 : 0);
    end
    // Hold, loads, wrap after load, clear beating load.
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      drv1(t1[s][0] != 0, t1[s][1] != 0, t1[s][2] != 0, t1[s][3]);
      push(1, t1[s][4], t1[s][5] != 0, t1[s][6]);
    end
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      drv1(1, 0, 0, 0);
      push(1, i, 0, 0);
    end

    // Asynchronous reset between edges while q = 7.
    @(negedge clk);
    rst = 1'b1;
    #1;
    push(0, 0, 0, 0); push(1, 0, 0, 0); push(2, 0, 0, 0);
    ->mon_ev;
    #3;
    rst = 1'b0;
    push(1, 1, 0, 0);
    @(negedge clk);
    push(1, 2, 0, 0);
    @(negedge clk);
    drv1(0, 0, 0, 0);
    push(1, 2, 0, 0);

    // Two-stage counter: saturating statistics then clear.
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      drv2(1, 0);
      push(2, i % 4, (i % 4) == 0, (i / 4 > 3) ? 3 : i / 4);
    end
    @(negedge clk);
    drv2(0, 1);
    push(2, 0, 0, 0);
    @(negedge clk);
    drv2(0, 0);
    push(2, 0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
